dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arb_starve_cnt.sv | 34 +++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: the arbitration FSM state
// type and the default dmem address/data widths.
// Ports: none (package).
// Configuration: DMEM_ARB_STARVE_EN enables the VGA starvation guard in the
// arbiter. The FORCE state is always declared here but is only reachable in
// that build.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt
// Saturating count of the cycles a VGA read has been blocked by the processor.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   clear          : VGA read granted, so the count returns to zero
//   start          : the first blocked cycle, so the count loads one
//   inc            : a further blocked cycle, so the count advances
//   count [CNT_W]  : current wait count, which sticks at all-ones
// Configuration: instantiated only when DMEM_ARB_STARVE_EN is defined.
module dmem_arb_starve_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over start, and start wins over increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(1);
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one synchronous-read dmem port between the processor M stage and
// VGA read requests. The processor normally owns the port. A VGA read is
// granted in any cycle the processor does not access memory.
// Ports:
//   clock, reset                        : rising-edge clock, async active-high reset
//   proc_access/address/data/wren       : processor M-stage lw/sw
//   proc_q                              : dmem read data to the processor (W stage)
//   proc_stall                          : processor must hold its pipeline this cycle
//   vga_req, vga_address                : level VGA read request, held until granted
//   vga_gnt                             : VGA read issued to dmem this cycle
//   vga_valid, vga_q                    : VGA read data, one cycle after vga_gnt
//   dmem_address/data/wren, dmem_q      : the single dmem port
// Configuration: when DMEM_ARB_STARVE_EN is defined, a VGA read that has been
// blocked STARVE_LIMIT cycles is forced through by stalling the processor for
// one cycle. Without it, the processor has strict priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              proc_access,
  input  logic [ADDR_W-1:0] proc_address,
  input  logic [DATA_W-1:0] proc_data,
  input  logic              proc_wren,
  output logic [DATA_W-1:0] proc_q,
  output logic              proc_stall,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_address,
  output logic              vga_gnt,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_q,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
);

  arb_state_e state, next_state;
  logic       gnt;
  logic       starved;
  logic       proc_owns;

`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [CNT_W-1:0] wait_cnt;

  dmem_arb_starve_cnt #(
    .CNT_W(CNT_W)
  ) u_starve_cnt (
    .clock (clock),
    .reset (reset),
    .clear (vga_gnt),
    .start ((state == IDLE) && vga_req && proc_access),
    .inc   ((state == PEND) && vga_req && proc_access),
    .count (wait_cnt)
  );

  // The count is updated at the end of this cycle, so the read is forced
  // when this blocked cycle brings it up to STARVE_LIMIT.
  assign starved    = (wait_cnt >= LIMIT_M1);
  assign proc_stall = (state == FORCE);
`else
  localparam bit STARVE_ON = 1'b0;

  assign starved    = 1'b0;
  assign proc_stall = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the raw grant. A VGA read is granted whenever the
  // processor leaves the port free, or unconditionally in FORCE.
  always_comb begin
    next_state = state;
    gnt        = 1'b0;
    unique case (state)
      IDLE: begin
        if (vga_req) begin
          if (!proc_access) begin
            gnt = 1'b1;
          end else if (STARVE_ON && (STARVE_LIMIT <= 1)) begin
            next_state = FORCE;
          end else begin
            next_state = PEND;
          end
        end
      end
      PEND: begin
        if (!vga_req) begin
          next_state = IDLE;
        end else if (!proc_access) begin
          gnt        = 1'b1;
          next_state = IDLE;
        end else if (starved) begin
          next_state = FORCE;
        end
      end
      FORCE: begin
        gnt        = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // While reset is held, no read may be issued and no write may land.
  assign vga_gnt   = gnt & ~reset;
  assign proc_owns = proc_access & (state != FORCE);

  assign dmem_address = proc_owns ? proc_address : vga_address;
  assign dmem_data    = proc_data;
  assign dmem_wren    = proc_access & proc_wren & ~proc_stall & ~reset;

  // Read data returns one cycle after the grant, so valid trails the grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_valid <= 1'b0;
    end else begin
      vga_valid <= vga_gnt;
    end
  end

  assign vga_q  = dmem_q;
  assign proc_q = dmem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Randomised and directed bench for dmem_arbiter. A behavioural model keeps
// how long the current VGA request has waited and a reference copy of memory.
// Expected read data is queued when a read is issued. A monitor checks that
// data when vga_valid or a due processor read appears.
// Honours DMEM_ARB_STARVE_EN so it matches the build of the design.
module tb_dmem_arbiter;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 8;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              proc_access;
  logic [ADDR_W-1:0] proc_address;
  logic [DATA_W-1:0] proc_data;
  logic              proc_wren;
  logic [DATA_W-1:0] proc_q;
  logic              proc_stall;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_address;
  logic              vga_gnt;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_q;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_data;
  logic              dmem_wren;
  logic [DATA_W-1:0] dmem_q;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] vga_exp_q  [$];
  logic [DATA_W-1:0] proc_exp_q [$];
  int  waited      = 0;
  bit  prev_gnt    = 1'b0;
  bit  last_gnt    = 1'b0;
  bit  proc_rd_now = 1'b0;
  bit  proc_rd_due = 1'b0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .proc_access (proc_access),
    .proc_address(proc_address),
    .proc_data   (proc_data),
    .proc_wren   (proc_wren),
    .proc_q      (proc_q),
    .proc_stall  (proc_stall),
    .vga_req     (vga_req),
    .vga_address (vga_address),
    .vga_gnt     (vga_gnt),
    .vga_valid   (vga_valid),
    .vga_q       (vga_q),
    .dmem_address(dmem_address),
    .dmem_data   (dmem_data),
    .dmem_wren   (dmem_wren),
    .dmem_q      (dmem_q)
  );

  function automatic logic [DATA_W-1:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory behind the dmem port: synchronous read, one cycle latency.
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = seed_word(i);
    dmem_q = '0;
    forever begin
      @(posedge clock);
      dmem_q <= ram[dmem_address];
      if (dmem_wren) ram[dmem_address] <= dmem_data;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) proc_rd_due <= 1'b0;
    else       proc_rd_due <= proc_rd_now;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Monitor: compares read data whenever the DUT presents it.
  always @(negedge clock) begin
    if (!reset) begin
      if (vga_valid) begin
        if (vga_exp_q.size() == 0) checkOutput("vga_valid_unexpected", 32'd1, 32'd0);
        else checkOutput("vga_q", vga_q, vga_exp_q.pop_front());
      end
      if (proc_rd_due) begin
        if (proc_exp_q.size() == 0) checkOutput("proc_read_unexpected", 32'd1, 32'd0);
        else checkOutput("proc_q", proc_q, proc_exp_q.pop_front());
      end
    end
  end

  // One cycle: drive the inputs, derive the expected port ownership from the
  // waiting-time rule, check it, and queue the expected read data.
  task automatic applyStimulus(input bit req, input logic [ADDR_W-1:0] vaddr,
                               input bit pacc, input logic [ADDR_W-1:0] paddr,
                               input logic [DATA_W-1:0] pdata, input bit pwren);
    bit force_now, exp_gnt, exp_wren;
    logic [ADDR_W-1:0] exp_addr;
    @(negedge clock);
    vga_req      = req;
    vga_address  = vaddr;
    proc_access  = pacc;
    proc_address = paddr;
    proc_data    = pdata;
    proc_wren    = pwren;
    force_now = STARVE_ON && (waited >= STARVE_LIMIT);
    exp_gnt   = force_now || (req && !pacc);
    exp_wren  = pacc && pwren && !force_now;
    exp_addr  = (pacc && !force_now) ? paddr : vaddr;
    #1;
    checkOutput("vga_gnt", 32'(vga_gnt), 32'(exp_gnt));
    checkOutput("proc_stall", 32'(proc_stall), 32'(force_now));
    checkOutput("dmem_wren", 32'(dmem_wren), 32'(exp_wren));
    checkOutput("dmem_address", 32'(dmem_address), 32'(exp_addr));
    checkOutput("vga_valid", 32'(vga_valid), 32'(prev_gnt));
    if (exp_wren) checkOutput("dmem_data", dmem_data, pdata);
    if (exp_gnt) vga_exp_q.push_back(ref_mem[vaddr]);
    proc_rd_now = pacc && !pwren && !force_now;
    if (proc_rd_now) proc_exp_q.push_back(ref_mem[paddr]);
    if (exp_wren) ref_mem[paddr] = pdata;
    if (exp_gnt || !req) waited = 0;
    else waited++;
    prev_gnt = exp_gnt;
    last_gnt = exp_gnt;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Async reset shortly after a rising edge; everything in flight is dropped.
  task automatic pulseReset(input int cycles);
    @(posedge clock);
    #2;
    reset = 1'b1;
    vga_exp_q.delete();
    proc_exp_q.delete();
    waited      = 0;
    prev_gnt    = 1'b0;
    proc_rd_now = 1'b0;
    #1;
    checkOutput("reset_vga_valid", 32'(vga_valid), 32'd0);
    checkOutput("reset_vga_gnt", 32'(vga_gnt), 32'd0);
    checkOutput("reset_proc_stall", 32'(proc_stall), 32'd0);
    checkOutput("reset_dmem_wren", 32'(dmem_wren), 32'd0);
    repeat (cycles) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit                req_hold;
    logic [ADDR_W-1:0] va;
    int                busy_pct;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = seed_word(i);
    reset        = 1'b1;
    vga_req      = 1'b0;
    vga_address  = '0;
    proc_access  = 1'b1;
    proc_address = '0;
    proc_data    = '0;
    proc_wren    = 1'b1;
    pulseReset(2);

    // Single VGA read with the processor idle.
    applyStimulus(1'b1, 12'h040, 1'b0, '0, '0, 1'b0);
    idleCycle();

    // Processor store collides with a VGA read; VGA goes once the port frees.
    applyStimulus(1'b1, 12'h100, 1'b1, 12'h010, 32'h0000_DEAD, 1'b1);
    applyStimulus(1'b1, 12'h100, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 12'h010, '0, 1'b0);
    idleCycle();

    // Sustained processor traffic against a held VGA request.
    for (int c = 0; c < (STARVE_ON ? 10 : 50); c++)
      applyStimulus(1'b1, 12'h0A5, 1'b1, 12'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, 12'h0A5, 1'b0, '0, '0, 1'b0);
    idleCycle();

    // Request withdrawn while blocked: no grant.
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 12'h033, 1'b1, 12'h020, '0, 1'b0);
    applyStimulus(1'b0, 12'h033, 1'b1, 12'h021, '0, 1'b0);
    idleCycle();

    // Four back-to-back VGA reads.
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 12'(12'h200 + c), 1'b0, '0, '0, 1'b0);
    idleCycle();

    // Reset the cycle after a grant while the request stays high.
    applyStimulus(1'b1, 12'h077, 1'b0, '0, '0, 1'b0);
    pulseReset(2);
    applyStimulus(1'b1, 12'h077, 1'b0, '0, '0, 1'b0);
    idleCycle();

    // Random traffic in three processor load phases; VGA holds until granted.
    req_hold = 1'b0;
    va       = '0;
    for (int i = 0; i < 600; i++) begin
      busy_pct = (i < 200) ? 30 : ((i < 400) ? 95 : 60);
      if (!req_hold) begin
        req_hold = ($urandom_range(0, 99) < 50);
        va       = 12'($urandom_range(0, 63));
      end
      applyStimulus(req_hold, va, ($urandom_range(0, 99) < busy_pct),
                    12'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
      if (last_gnt) req_hold = 1'b0;
    end

    // The VGA request may still be pending here; keep the port free until it goes.
    for (int c = 0; (c < 4) && req_hold; c++) begin
      applyStimulus(1'b1, va, 1'b0, '0, '0, 1'b0);
      if (last_gnt) req_hold = 1'b0;
    end
    repeat (3) idleCycle();
    checkOutput("vga_reads_outstanding", 32'(vga_exp_q.size()), 32'd0);
    checkOutput("proc_reads_outstanding", 32'(proc_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
